// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter: datapath width, ALU opcodes, FSM state codes
// and the operation legality rule used to screen requests before issue.
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4
    } opcode_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Encodings 5..7 are undefined; DIV/MOD by zero must never reach the ALU.
    function automatic logic op_legal(input logic [OP_W-1:0]   op,
                                      input logic [DATA_W-1:0] b);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: ok = 1'b1;
            OP_DIV, OP_MOD:         ok = (b != '0);
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NREQ. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
                any_o                              = 1'b1;
                gnt_o[(int'(ptr_i) + k) % NREQ]    = 1'b1;
                gnt_idx_o                          = IDX_W'((int'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-latency 8-bit ALU between NREQ requesters, one
// transaction in flight, round-robin grant, illegal ops answered without issue.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]   req_op,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]      resp_data,
    output logic                   resp_err,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output opcode_t                alu_mode,
    output logic                   alu_start,
    input  logic [DATA_W-1:0]      alu_c
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    opcode_t           alu_mode_q, alu_mode_d;
    logic              alu_start_q, alu_start_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [OP_W-1:0]   sel_op;
    logic [IDX_W-1:0]  ptr_next;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    assign sel_a  = req_a[int'(arb_idx)*DATA_W +: DATA_W];
    assign sel_b  = req_b[int'(arb_idx)*DATA_W +: DATA_W];
    assign sel_op = req_op[int'(arb_idx)*OP_W +: OP_W];

    assign ptr_next = (gnt_idx_q == IDX_W'(NREQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

    // Grant is offered only while idle; gating with reset keeps a reset cycle from
    // looking like a completed handshake to the requester.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && !reset) begin
            req_ready = arb_gnt;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == ST_RESP) begin
            resp_valid[gnt_idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_mode_d  = alu_mode_q;
        alu_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    gnt_idx_d = arb_idx;
                    if (op_legal(sel_op, sel_b)) begin
                        alu_a_d     = sel_a;
                        alu_b_d     = sel_b;
                        alu_mode_d  = opcode_t'(sel_op);
                        alu_start_d = 1'b1;
                        state_d     = ST_ISSUE;
                    end else begin
                        // Blocked op: answer straight away, ALU registers untouched.
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(ALU_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    resp_data_d = alu_c;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready[gnt_idx_q]) begin
                    rr_ptr_d = ptr_next;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_mode_q  <= OP_ADD;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_mode_q  <= alu_mode_d;
            alu_start_q <= alu_start_d;
        end
    end

    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign alu_start = alu_start_q;

    a_req_ready_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(req_ready));
    a_resp_valid_onehot0: assert property (@(posedge clock) disable iff (reset)
        $onehot0(resp_valid));
    a_start_only_in_issue: assert property (@(posedge clock) disable iff (reset)
        alu_start |-> (state_q == ST_ISSUE));

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, all checked
// against a transaction-level model of grant order, latency and results.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ    = 3;
    localparam int ALU_LAT = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ*8-1:0]    req_a, req_b;
    logic [NREQ*3-1:0]    req_op;
    logic [7:0]           resp_data, alu_a, alu_b, alu_c;
    logic                 resp_err, alu_start;
    opcode_t              alu_mode;

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_mode   (alu_mode),
        .alu_start  (alu_start),
        .alu_c      (alu_c)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        int r;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            3'd2: r = int'(a) * int'(b);
            3'd3: r = (b == 0) ? 0 : int'(a) / int'(b);
            3'd4: r = (b == 0) ? 0 : int'(a) % int'(b);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    // ALU: result of an issued op appears ALU_LAT edges later for one cycle only.
    logic [7:0] pipe [ALU_LAT];
    always @(posedge clock) begin
        pipe[0] <= alu_start ? ref_op(3'(alu_mode), alu_a, alu_b)
                             : ~ref_op(3'(alu_mode), alu_a, alu_b);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_c = pipe[ALU_LAT-1];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, rr = 0, g = 0, acc_cyc = 0, resp_at = 0, acc_i = -1;
    bit busy = 0, exp_err = 0;
    logic [7:0] exp_data, ex_a, ex_b;
    logic [2:0] ex_op;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample 1 ns after the drive point, check against the model, advance one cycle.
    task automatic step();
        int w, idx;
        logic [7:0] a_v, b_v;
        logic [2:0] op_v;
        #1;
        acc_i = -1;
        if (reset) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            busy = 0;
            rr   = 0;
        end else if (!busy) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
            chk("resp_valid_idle", 32'(resp_valid), 32'd0);
            chk("alu_start_idle", 32'(alu_start), 32'd0);
            if (w >= 0) begin
                a_v = req_a[w*8 +: 8];
                b_v = req_b[w*8 +: 8];
                op_v = req_op[w*3 +: 3];
                busy = 1; g = w; acc_i = w; acc_cyc = cyc;
                ex_a = a_v; ex_b = b_v; ex_op = op_v;
                exp_err  = (op_v > 3'd4) || (op_v >= 3'd3 && b_v == 8'd0);
                exp_data = exp_err ? 8'd0 : ref_op(op_v, a_v, b_v);
                resp_at  = cyc + (exp_err ? 1 : ALU_LAT + 2);
            end
        end else begin
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            chk("alu_start", 32'(alu_start), 32'(!exp_err && cyc == acc_cyc + 1));
            if (!exp_err && cyc > acc_cyc && cyc < resp_at) begin
                chk("alu_a", 32'(alu_a), 32'(ex_a));
                chk("alu_b", 32'(alu_b), 32'(ex_b));
                chk("alu_mode", 32'(alu_mode), 32'(ex_op));
            end
            if (cyc < resp_at) begin
                chk("resp_valid_early", 32'(resp_valid), 32'd0);
            end else begin
                chk("resp_valid", 32'(resp_valid), 32'd1 << g);
                chk("resp_data", 32'(resp_data), 32'(exp_data));
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                if (resp_ready[g]) begin
                    busy = 0;
                    rr   = (g + 1) % NREQ;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic set_req(input int i, input logic v, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_valid[i]       = v;
        req_op[i*3 +: 3]   = op;
        req_a[i*8 +: 8]    = a;
        req_b[i*8 +: 8]    = b;
    endtask

    task automatic wait_grant(input int i);
        acc_i = -1;
        for (int n = 0; n < 50 && acc_i < 0; n++) step();
        chk("grant_to", 32'(acc_i), 32'(i));
    endtask

    task automatic run_until_idle();
        for (int n = 0; n < 60 && busy; n++) step();
        chk("idle_timeout", 32'(busy), 32'd0);
        busy = 0;
    endtask

    task automatic check_reset();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_mode", 32'(alu_mode), 32'(OP_ADD));
        chk("rst_alu_start", 32'(alu_start), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) step();
        reset = 1'b0;
        check_reset();
    endtask

    int order[$];
    int cnt[NREQ];

    initial begin
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; resp_ready = '1;
        do_reset();

        // Single requester ADD, then DIV 200/7 through the full ALU latency.
        set_req(0, 1, 3'(OP_ADD), 8'd100, 8'd27);
        wait_grant(0);
        req_valid[0] = 0;
        run_until_idle();
        set_req(0, 1, 3'(OP_DIV), 8'd200, 8'd7);
        wait_grant(0);
        req_valid[0] = 0;
        run_until_idle();

        // Two requesters held from reset alternate 0,1,0,1.
        do_reset();
        set_req(0, 1, 3'(OP_MUL), 8'd16, 8'd17);
        set_req(1, 1, 3'(OP_SUB), 8'd3, 8'd5);
        order.delete();
        for (int n = 0; n < 100 && order.size() < 4; n++) begin
            step();
            if (acc_i >= 0) order.push_back(acc_i);
        end
        req_valid = '0;
        run_until_idle();
        chk("alt_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size(); k++) chk("alt_order", 32'(order[k]), 32'(k % 2));

        // DIV by zero is blocked, then a legal MOD.
        set_req(1, 1, 3'(OP_DIV), 8'd50, 8'd0);
        wait_grant(1);
        req_valid[1] = 0;
        run_until_idle();
        set_req(1, 1, 3'(OP_MOD), 8'd50, 8'd7);
        wait_grant(1);
        req_valid[1] = 0;
        run_until_idle();
        set_req(2, 1, 3'd6, 8'd1, 8'd1);
        wait_grant(2);
        req_valid[2] = 0;
        run_until_idle();

        // Back-pressure on requester 1 while requester 0 waits.
        resp_ready = '0;
        set_req(1, 1, 3'(OP_SUB), 8'd9, 8'd4);
        wait_grant(1);
        req_valid[1] = 0;
        set_req(0, 1, 3'(OP_ADD), 8'd1, 8'd2);
        repeat (ALU_LAT + 1 + 5) step();
        chk("bp_still_busy", 32'(busy), 32'd1);
        resp_ready = '1;
        step();
        wait_grant(0);
        req_valid[0] = 0;
        run_until_idle();

        // Reset during WAIT drops the transaction and clears the pointer.
        set_req(2, 1, 3'(OP_MUL), 8'd7, 8'd9);
        wait_grant(2);
        req_valid[2] = 0;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset();
        set_req(0, 1, 3'(OP_ADD), 8'd5, 8'd6);
        set_req(1, 1, 3'(OP_SUB), 8'd20, 8'd1);
        wait_grant(0);
        req_valid[0] = 0;
        run_until_idle();
        wait_grant(1);
        req_valid[1] = 0;
        run_until_idle();

        // Fairness with every requester continuously active.
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            set_req(i, 1, 3'(OP_ADD), 8'(i), 8'd1);
        end
        for (int n = 0, t = 0; n < 200 && t < 3 * NREQ; n++) begin
            step();
            if (acc_i >= 0) begin
                cnt[acc_i]++;
                t++;
            end
        end
        req_valid = '0;
        run_until_idle();
        for (int i = 0; i < NREQ; i++) chk("fair_count", 32'(cnt[i]), 32'd3);

        // Random traffic with random back-pressure.
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (acc_i == i || !req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 1, 3'($urandom_range(0, 7)), 8'($urandom),
                                ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom));
                    else
                        req_valid[i] = 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 0;
                end
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        req_valid = '0;
        resp_ready = '1;
        run_until_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one simple 8-bit ALU between NREQ requesters.
- Round-robin grant; each transaction is one operation with a valid/ready request and a valid/ready response.
- Sequences the ALU: drives operands and opcode, waits out its registered latency, captures the result and returns it to the granted requester.
- Blocks divide/modulo by zero and illegal opcodes before issue, so the ALU never sees them.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ALU_LAT, 1, cycles from the issue edge until alu_c holds the result (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; one-hot or zero.
- req_a  in  NREQ*8  operand a, requester i at bits [8i+7:8i].
- req_b  in  NREQ*8  operand b, same packing.
- req_op  in  NREQ*3  opcode (opcode type), same packing.
- resp_valid  out  NREQ  response valid to granted requester; one-hot or zero.
- resp_ready  in  NREQ  per-requester response accept.
- resp_data  out  8  result, shared by all requesters.
- resp_err  out  1  response flags a blocked operation.
- alu_a, alu_b  out  8 each  ALU operands.
- alu_mode  out  opcode  ALU mode_select.
- alu_start  out  1  one-cycle issue strobe.
- alu_c  in  8  ALU result.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset: state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, alu_a=0, alu_b=0, alu_mode=ADD, alu_start=0, wait counter=0.
- Reset mid-transaction: the transaction is dropped with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant:
  - Winner g is the first asserted req_valid at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle only; the handshake completes at that edge.
  - Operands and op are latched into holding registers, together with g.
- IDLE, transitions:
  - Op is DIV or MOD with b==0, or op is an undefined encoding: -> RESP with resp_err=1, resp_data=0, ALU untouched.
  - Otherwise -> ISSUE.
- ISSUE:
  - alu_a/alu_b/alu_mode are driven from the holding registers; alu_start=1 for exactly this cycle.
  - Counter loads ALU_LAT-1; -> WAIT.
- WAIT:
  - ALU inputs stay stable; alu_start=0.
  - Counter decrements each cycle. When it is 0, alu_c is captured into resp_data, resp_err=0, -> RESP.
- RESP:
  - resp_valid[g]=1; resp_data and resp_err stay stable until resp_ready[g].
  - On the handshake edge: -> IDLE, rr_ptr=(g+1) mod NREQ.
  - Back-pressure can last any number of cycles.
- Latency:
  - Normal: accept edge -> resp_valid high after ALU_LAT+1 further cycles (ALU_LAT=1: 2 cycles).
  - Error: 1 cycle.
- Throughput: one transaction in flight. No new grant before the RESP handshake; req_ready=0 in ISSUE/WAIT/RESP.
- Deasserting req_valid before grant is allowed; the requester is simply skipped.
- Arithmetic is the ALU's 8-bit truncated result, unsigned:
  - SUB wraps: 3-5 = 8'hFE.
  - MUL keeps the low 8 bits.
- Simultaneous requests: only the round-robin winner is granted; the others keep req_valid held.
- Fairness: with all requesters continuously active, every requester is served once per NREQ transactions.
- Assertions: req_ready and resp_valid are each $onehot0; alu_start is never high outside ISSUE.

Decomposition:
- Shared package (existing tb_pkg): opcode enum (ADD, SUB, MUL, DIV, MOD), DATA_W=8, and the arbiter state enum.
- One sub-module, rr_arbiter: NREQ-wide round-robin priority pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-request flag.
  - Purely combinational; the pointer register lives in alu_arbiter.

Test Plan:
- Single requester 0, ADD a=8'd100 b=8'd27, resp_ready held 1 -> req_ready[0] for 1 cycle; resp_valid[0] 2 cycles later; resp_data=127, resp_err=0.
- Requesters 0 and 1 both valid from reset, repeated ops (0: MUL 16*17, 1: SUB 3-5) -> grant order 0,1,0,1; results 8'h10 (272 mod 256) and 8'hFE.
- DIV a=50 b=0 from requester 1 -> resp after 1 cycle, resp_err=1, resp_data=0, alu_start never asserted. Then MOD 50%7 -> 1, resp_err=0.
- Back-pressure: SUB 9-4, resp_ready low for 5 cycles -> resp_valid and resp_data=5 held stable; requester 0 valid meanwhile sees no req_ready until the handshake.
- ALU_LAT=3 build, DIV 200/7 -> alu_start exactly 1 cycle; result 28 captured 3 cycles after the issue edge; ALU inputs stable throughout WAIT.
- Reset asserted in WAIT -> next cycle all outputs at reset values, rr_ptr=0. A following request from requester 1 is served normally.
